// File: rtl/branch_pc_unit_pkg.sv
// Shared datapath constants and the PC-stage state type for the RV32I core.
package RISCV_PKG;

    localparam int REG_WIDTH = 32;
    localparam logic [REG_WIDTH-1:0] PC_STEP = 32'd4;

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALT
    } pc_state_t;

endpackage

// File: rtl/branch_pc_unit_if.sv
// Fetch-address handshake between the PC stage and instruction memory.
interface branch_pc_unit_if;

    logic [RISCV_PKG::REG_WIDTH-1:0] PC;
    logic                            FetchValid;
    logic                            FetchReady;

    modport master (output PC, FetchValid, input FetchReady);
    modport slave  (input PC, FetchValid, output FetchReady);

endinterface

// File: rtl/branch_pc_unit_target_gen.sv
// Control-flow target selection with JALR > JAL > branch priority and alignment check.
module branch_target_gen
    import RISCV_PKG::*;
(
    input  logic                 valid,
    input  logic                 branch,
    input  logic                 jump,
    input  logic                 jump_reg,
    input  logic                 one,
    input  logic [REG_WIDTH-1:0] alu_output,
    input  logic [REG_WIDTH-1:0] ex_pc,
    input  logic [REG_WIDTH-1:0] immediate,
    output logic                 taken,
    output logic [REG_WIDTH-1:0] target,
    output logic                 misaligned
);

    always_comb begin
        // NOTE: target gets a default before the override so no latch is inferred.
        target = ex_pc + immediate;
        if (jump_reg) begin
            target = alu_output & ~32'h1;
        end
    end

    assign taken      = valid & (jump_reg | jump | (branch & one));
    assign misaligned = taken & target[1];

endmodule

// File: rtl/branch_pc_unit.sv
// Architectural PC register, BOOT/RUN/HALT sequencing and redirect/flush generation.
module branch_pc_unit
    import RISCV_PKG::*;
#(
    parameter logic [REG_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    Valid,
    input  logic                    Branch,
    input  logic                    Jump,
    input  logic                    JumpReg,
    input  logic                    ONE,
    input  logic [REG_WIDTH-1:0]    ALUOutput,
    input  logic [REG_WIDTH-1:0]    ExPC,
    input  logic [REG_WIDTH-1:0]    Immediate,
    input  logic                    Stall,
    branch_pc_unit_if.master        fetch,
    output logic [REG_WIDTH-1:0]    LinkAddr,
    output logic                    Flush,
    output logic                    MisalignErr,
    output logic [REG_WIDTH-1:0]    BadAddr
);

    pc_state_t            state;
    logic [REG_WIDTH-1:0] pc_q;
    logic                 taken;
    logic                 misaligned;
    logic [REG_WIDTH-1:0] target;
    logic                 running;

    branch_target_gen u_target_gen (
        .valid      (Valid),
        .branch     (Branch),
        .jump       (Jump),
        .jump_reg   (JumpReg),
        .one        (ONE),
        .alu_output (ALUOutput),
        .ex_pc      (ExPC),
        .immediate  (Immediate),
        .taken      (taken),
        .target     (target),
        .misaligned (misaligned)
    );

    assign running     = (state == RUN);
    assign Flush       = running & taken;
    assign MisalignErr = running & misaligned;
    assign LinkAddr    = ExPC + PC_STEP;

    assign fetch.PC         = pc_q;
    assign fetch.FetchValid = running;

    // NOTE: rst_n is absent from the sensitivity list, so reset is synchronous;
    // all state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= BOOT;
            pc_q    <= RESET_PC;
            BadAddr <= '0;
        end else begin
            case (state)
                BOOT: state <= RUN;
                RUN: begin
                    if (taken) begin
                        // A redirect overrides stall and backpressure; misaligned targets halt fetch.
                        if (misaligned) begin
                            BadAddr <= target;
                            state   <= HALT;
                        end else begin
                            pc_q <= target;
                        end
                    end else if (fetch.FetchReady && !Stall) begin
                        pc_q <= pc_q + PC_STEP;
                    end
                end
                HALT:    state <= HALT;
                default: state <= BOOT;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_pc_unit.sv
// Randomised and directed bench for branch_pc_unit against a cycle-level behavioural model.
module tb_branch_pc_unit;
    import RISCV_PKG::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        Valid, Branch, Jump, JumpReg, ONE, Stall;
    logic [31:0] ALUOutput, ExPC, Immediate;
    logic [31:0] LinkAddr, BadAddr;
    logic        Flush, MisalignErr;

    branch_pc_unit_if fif ();

    branch_pc_unit #(.RESET_PC(RST_PC)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .Valid       (Valid),
        .Branch      (Branch),
        .Jump        (Jump),
        .JumpReg     (JumpReg),
        .ONE         (ONE),
        .ALUOutput   (ALUOutput),
        .ExPC        (ExPC),
        .Immediate   (Immediate),
        .Stall       (Stall),
        .fetch       (fif),
        .LinkAddr    (LinkAddr),
        .Flush       (Flush),
        .MisalignErr (MisalignErr),
        .BadAddr     (BadAddr)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: fetch address, faulting address, and two flags for "has left boot" / "has halted".
    logic        mdl_known = 1'b0;
    logic        booted, halted;
    logic [31:0] exp_pc, exp_bad;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic idle_ex();
        Valid = 0; Branch = 0; Jump = 0; JumpReg = 0; ONE = 0;
        ALUOutput = 0; ExPC = 32'h0000_0500; Immediate = 0;
    endtask

    // Check outputs mid-cycle, then advance the model across the next rising edge.
    task automatic cycle();
        logic [31:0] tgt;
        logic        tkn, live;
        @(negedge clk);
        tgt  = JumpReg ? ((ALUOutput >> 1) << 1) : (ExPC + Immediate);
        tkn  = Valid && (JumpReg || Jump || (Branch && ONE));
        live = booted && !halted;
        check("LinkAddr", LinkAddr, ExPC + 32'd4);
        if (mdl_known) begin
            check("PC", fif.PC, exp_pc);
            check("FetchValid", 32'(fif.FetchValid), 32'(live));
            check("BadAddr", BadAddr, exp_bad);
            check("Flush", 32'(Flush), 32'(live && tkn));
            check("MisalignErr", 32'(MisalignErr), 32'(live && tkn && tgt[1]));
        end
        @(posedge clk);
        if (!rst_n) begin
            mdl_known = 1; booted = 0; halted = 0; exp_pc = RST_PC; exp_bad = 0;
        end else if (mdl_known) begin
            if (!booted) booted = 1;
            else if (!halted) begin
                if (tkn && tgt[1]) begin
                    halted = 1; exp_bad = tgt;
                end else if (tkn) exp_pc = tgt;
                else if (fif.FetchReady && !Stall) exp_pc = exp_pc + 32'd4;
            end
        end
        #1;
    endtask

    initial begin
        rst_n = 0; Stall = 0; fif.FetchReady = 0;
        idle_ex();
        cycle(); cycle();

        // Sequential fetch from RESET_PC.
        rst_n = 1; fif.FetchReady = 1;
        repeat (4) cycle();

        // Taken branch, then the same branch not taken.
        Valid = 1; Branch = 1; ONE = 1; ExPC = 32'h200; Immediate = -32'sd8;
        cycle();
        check("branch_target", fif.PC, 32'h1F8);
        ONE = 0;
        cycle();
        idle_ex(); cycle();

        // JALR beats JAL when both are set.
        Valid = 1; JumpReg = 1; Jump = 1; ALUOutput = 32'h1235; ExPC = 32'h300; Immediate = 32'h40;
        cycle();
        check("jalr_target", fif.PC, 32'h1234);
        idle_ex(); cycle();

        // Stall, a redirect during stall, then backpressure.
        Stall = 1;
        repeat (3) cycle();
        Valid = 1; Branch = 1; ONE = 1; ExPC = 32'h800; Immediate = 32'h20;
        cycle();
        idle_ex(); cycle();
        Stall = 0; fif.FetchReady = 0;
        repeat (3) cycle();
        fif.FetchReady = 1;

        // Wrap from the top of the address space.
        Valid = 1; JumpReg = 1; ALUOutput = 32'hFFFF_FFFC;
        cycle();
        idle_ex(); cycle(); cycle();
        check("pc_wrap", fif.PC, 32'h4);

        // Reset in the resolution cycle of a misaligned jump wins.
        Valid = 1; Jump = 1; ExPC = 32'h40; Immediate = 32'h6; rst_n = 0;
        cycle();
        idle_ex(); rst_n = 1;
        repeat (3) cycle();

        // Misaligned JAL halts; later redirects are ignored.
        Valid = 1; Jump = 1; ExPC = 32'h40; Immediate = 32'h6;
        cycle();
        check("bad_addr", BadAddr, 32'h46);
        Branch = 1; ONE = 1; Immediate = 32'h100;
        repeat (3) cycle();
        idle_ex(); rst_n = 0; cycle(); rst_n = 1;

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            rst_n          = ($urandom_range(0, 39) != 0);
            Valid          = ($urandom_range(0, 3) != 0);
            Branch         = $urandom_range(0, 1);
            Jump           = ($urandom_range(0, 5) == 0);
            JumpReg        = ($urandom_range(0, 9) == 0);
            ONE            = $urandom_range(0, 1);
            ALUOutput      = $urandom;
            ExPC           = $urandom & 32'hFFFF_FFFC;
            Immediate      = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            Stall          = ($urandom_range(0, 3) == 0);
            fif.FetchReady = ($urandom_range(0, 3) != 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_pc_unit.md
# branch_pc_unit

Program-counter and control-flow resolution stage of the RV32I datapath. It consumes the ALU's compare bit (`ONE`) and, for JALR, its sum output (`ALUOutput`) from the execute stage, and decides whether the next fetch address is sequential or redirected. It owns the architectural PC register and drives a valid/ready fetch-address handshake to instruction memory. Misaligned control-flow targets are flagged and halt fetch.

## Interface
- `RESET_PC`, default 32'h0000_0000, fetch address loaded on reset
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: synchronous, active-low reset
- `Valid` in 1: EX-stage instruction is valid this cycle
- `Branch` in 1: EX instruction is a conditional branch (ALU computes the condition into `ONE`)
- `Jump` in 1: EX instruction is JAL
- `JumpReg` in 1: EX instruction is JALR (ALU computes rs1+imm)
- `ONE` in 1: ALU compare result bit
- `ALUOutput` in REG_WIDTH: ALU result
- `ExPC` in REG_WIDTH: PC of the EX instruction
- `Immediate` in REG_WIDTH: sign-extended B/J immediate
- `Stall` in 1: hazard unit holds PC
- `FetchReady` in 1: instruction memory accepts `PC`
- `PC` out REG_WIDTH: current fetch address (registered)
- `FetchValid` out 1: `PC` is a valid fetch request
- `LinkAddr` out REG_WIDTH: ExPC+4 for rd writeback (combinational)
- `Flush` out 1: kill IF/ID contents this cycle
- `MisalignErr` out 1: misaligned-target pulse
- `BadAddr` out REG_WIDTH: faulting target (registered)

## Operation
- FSM states: BOOT, RUN, HALT. Reset → BOOT; BOOT → RUN after one cycle; RUN → HALT on misaligned redirect; HALT is left only through reset.
- Taken = `Valid` & (`JumpReg` | `Jump` | (`Branch` & `ONE`)); it is evaluated only in RUN and ignored in BOOT/HALT.
- Target priority when more than one flag is set: `JumpReg` > `Jump` > `Branch`.
  - `JumpReg` target = {ALUOutput[31:1],1'b0}.
  - `Jump`/`Branch` target = ExPC + Immediate, mod 2^32.
- Misaligned: Taken and target[1] = 1.
  - `Flush`=1 and `MisalignErr`=1 in the same cycle.
  - `BadAddr`<=target and state <= HALT at the next edge; `PC` is unchanged.
- Aligned Taken: `Flush`=1 combinationally and `PC`<=target at the next edge. A redirect overrides `Stall` and `FetchReady`.
- Sequential advance (RUN, not Taken): `PC`<=PC+4 iff `FetchValid` & `FetchReady` & !`Stall`. Otherwise `PC` holds. PC+4 wraps from 32'hFFFF_FFFC to 0.
- `FetchValid` = (state==RUN). While it is high and not accepted, `PC` is stable except on a redirect.
- `LinkAddr` = ExPC+4 (wraps), independent of state.

## Timing
- Reset values (at the edge where `rst_n`=0): `PC`=RESET_PC, `FetchValid`=0, `Flush`=0, `MisalignErr`=0, `BadAddr`=0, state BOOT.
- Reset asserted mid-redirect or in HALT wins: all registers take their reset values at that edge.
- First fetch request: one cycle after `rst_n` rises, with `FetchValid`=1 and `PC`=RESET_PC.
- Redirect latency: resolution in cycle N (`Flush` high in N) → `PC`=target in cycle N+1. There is no bubble cycle.
- `Flush` and `MisalignErr` are single-cycle, combinational from registered state and the EX inputs. They are never high in BOOT or HALT.
- Simultaneous Taken and fetch acceptance: the redirect wins and PC+4 is discarded.

## Structure
- `REG_WIDTH` and a `pc_state_t` enum (BOOT, RUN, HALT) go in `RISCV_PKG`. Add a `PC_STEP` constant (4) there as well.
- One sub-module: `branch_target_gen`, a combinational block for target select, priority, and the misalignment check. The FSM and PC register stay in the top module.

## Test plan
- Reset, then `rst_n`=1 with `FetchReady`=1, RESET_PC=32'h100 → cycle 1: `FetchValid`=0, `PC`=0x100. Following cycles: PC = 0x100, 0x104, 0x108, …
- Taken branch: `Valid`=`Branch`=`ONE`=1, ExPC=0x200, Immediate=-8 → `Flush`=1 that cycle; next cycle `PC`=0x1F8. Repeat with `ONE`=0 → no `Flush`, PC+4.
- JALR: ALUOutput=0x0000_1235, `JumpReg`=`Jump`=1 → target 0x1234 (JumpReg priority); `LinkAddr`=ExPC+4.
- Misaligned JAL: ExPC=0x40, Immediate=0x6 → `MisalignErr`=`Flush`=1; next cycle `BadAddr`=0x46, `FetchValid`=0, `PC` held. Further taken inputs are ignored until reset.
- Stall and backpressure: `Stall`=1 or `FetchReady`=0 for 3 cycles → PC stable and `FetchValid`=1. A taken branch during the stall still redirects next cycle.
- Wrap and reset: PC=0xFFFF_FFFC accepted → PC=0. Assert `rst_n`=0 in the resolution cycle → PC=RESET_PC and no HALT.
